// File: rtl/interrupt_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
package interrupt_pkg;

  localparam int NUM_IRQ_DEF  = 8;
  localparam int SPURIOUS_LVL = NUM_IRQ_DEF - 1;
  localparam int PRIO_MAX     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    ACK2  = 2'd2,
    DRIVE = 2'd3
  } ack_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } prio_t;

  // Lowest set index wins: IR0 is the highest priority level.
  function automatic prio_t prio_first(input logic [PRIO_MAX-1:0] vec);
    prio_t r;
    r = '0;
    for (int i = PRIO_MAX - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ack_if.sv
// Request/acknowledge/vector bus between the controller core and the sequencer.
interface irq_ack_if
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = 8
);
  localparam int LVL_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0]     irq_pending;
  logic [NUM_IRQ-1:0]     irq_mask;
  logic                   inta_n;
  logic                   eoi_valid;
  logic                   eoi_specific;
  logic [LVL_W-1:0]       eoi_level;
  logic [VEC_W-LVL_W-1:0] vector_base;
  logic                   int_out;
  logic [NUM_IRQ-1:0]     in_service;
  logic [NUM_IRQ-1:0]     irq_clear;
  logic [VEC_W-1:0]       data_out;
  logic                   data_out_en;

  modport master (
    output irq_pending, irq_mask, inta_n, eoi_valid, eoi_specific, eoi_level, vector_base,
    input  int_out, in_service, irq_clear, data_out, data_out_en
  );

  modport slave (
    input  irq_pending, irq_mask, inta_n, eoi_valid, eoi_specific, eoi_level, vector_base,
    output int_out, in_service, irq_clear, data_out, data_out_en
  );
endinterface

// File: rtl/priority_resolver.sv
// Combinational fixed-priority arbitration of unmasked requests against the in-service set.
module priority_resolver
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int LVL_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] pending,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] in_service,
  output logic               eligible_any,
  output logic [LVL_W-1:0]   winner
);

  prio_t              isr_p;
  prio_t              win_p;
  logic [NUM_IRQ-1:0] higher;
  logic [NUM_IRQ-1:0] eligible;

  assign isr_p = prio_first(PRIO_MAX'(in_service));

  // Only levels strictly above the highest in-service level may nest.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_higher
    assign higher[gi] = !isr_p.valid || (5'(gi) < isr_p.idx);
  end

  assign eligible     = pending & ~mask & higher;
  assign win_p        = prio_first(PRIO_MAX'(eligible));
  assign eligible_any = win_p.valid;
  assign winner       = LVL_W'(win_p.idx);

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INT/INTA acknowledge sequencer: owns the in-service register and drives the vector byte.
module interrupt_ack_sequencer
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  irq_ack_if.slave bus
);
  localparam int                 LVL_W   = $clog2(NUM_IRQ);
  localparam logic [NUM_IRQ-1:0] ONE_HOT = {{(NUM_IRQ-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]   SPUR    = LVL_W'(NUM_IRQ - 1);

  ack_state_t         state_q, state_d;
  logic               int_q, int_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] clr_q, clr_d;
  logic [VEC_W-1:0]   dout_q, dout_d;
  logic               den_q, den_d;
  logic [LVL_W-1:0]   ack_lvl_q, ack_lvl_d;
  logic               inta_prev_q, inta_prev_d;

  logic               eligible_any;
  logic [LVL_W-1:0]   winner;
  logic               ack_fall;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] eoi_vec;
  prio_t              isr_first;

  priority_resolver #(.NUM_IRQ(NUM_IRQ), .LVL_W(LVL_W)) u_resolver (
    .pending      (bus.irq_pending),
    .mask         (bus.irq_mask),
    .in_service   (isr_q),
    .eligible_any (eligible_any),
    .winner       (winner)
  );

  assign ack_fall  = inta_prev_q & ~bus.inta_n;
  assign isr_first = prio_first(PRIO_MAX'(isr_q));

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    clr_d       = '0;
    dout_d      = dout_q;
    den_d       = den_q;
    ack_lvl_d   = ack_lvl_q;
    inta_prev_d = bus.inta_n;
    set_vec     = '0;
    eoi_vec     = '0;

    case (state_q)
      IDLE: begin
        if (eligible_any) begin
          int_d   = 1'b1;
          state_d = ACK1;
        end
      end
      ACK1: begin
        if (ack_fall) begin
          // Winner is frozen here; a withdrawn request is acknowledged as spurious.
          if (eligible_any) begin
            ack_lvl_d = winner;
            set_vec   = ONE_HOT << winner;
            clr_d     = ONE_HOT << winner;
          end else begin
            ack_lvl_d = SPUR;
          end
          int_d   = 1'b0;
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (ack_fall) begin
          dout_d  = {bus.vector_base, ack_lvl_q};
          den_d   = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.inta_n) begin
          dout_d  = '0;
          den_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI selects from the pre-set value; a coincident set of the same bit wins.
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        if (int'(bus.eoi_level) < NUM_IRQ) eoi_vec = ONE_HOT << bus.eoi_level;
      end else if (isr_first.valid) begin
        eoi_vec = ONE_HOT << isr_first.idx;
      end
    end
    isr_d = (isr_q & ~eoi_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      int_q       <= 1'b0;
      isr_q       <= '0;
      clr_q       <= '0;
      dout_q      <= '0;
      den_q       <= 1'b0;
      ack_lvl_q   <= '0;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      isr_q       <= isr_d;
      clr_q       <= clr_d;
      dout_q      <= dout_d;
      den_q       <= den_d;
      ack_lvl_q   <= ack_lvl_d;
      inta_prev_q <= inta_prev_d;
    end
  end

  assign bus.int_out     = int_q;
  assign bus.in_service  = isr_q;
  assign bus.irq_clear   = clr_q;
  assign bus.data_out    = dout_q;
  assign bus.data_out_en = den_q;

endmodule
